lfsr_bank_ctrl: RTL
===================

Name: lfsr_bank_ctrl

Overview:
- Sequencer for a bank of NUM_LFSR Fibonacci LFSRs of width W. Each lane is seeded and tapped from a sliding window of shared seed and tap vectors.
- Runs a programmed number of steps, gated by a step enable (slow-clock tick used as an enable, not as a clock). Presents one output bit per lane per step with a valid strobe.
- Sits between the slow-clock tick generator and the LED/consumer logic. Replaces per-lane free-running LFSRs with a start/busy/done-controlled bank.

Parameters:
- W, 5, LFSR width per lane (>=2)
- NUM_LFSR, 7, number of lanes
- CNT_W, 16, width of step counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate run; return to IDLE next cycle, no done pulse
- step_en  in  1  step tick; one LFSR step per high cycle while RUN
- steps  in  CNT_W  number of steps for the run; sampled with start
- seed  in  W+NUM_LFSR-1  shared seed vector; lane i loads seed[i+W-1:i]
- taps  in  W+NUM_LFSR-1  shared tap vector; lane i uses taps[i+W-1:i]
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse at normal run completion
- bits_out  out  NUM_LFSR  lane output bits of the latest step
- bit_valid  out  1  one-cycle pulse when bits_out updates
- lockup  out  NUM_LFSR  sticky per-lane all-zero flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): all outputs 0; all lane states 0; counter 0; FSM = IDLE.
- Lane step: state s[W-1:0]. emitted bit = s[0]. fb = XOR-reduce(s & lane_taps). s_next = {fb, s[W-1:1]}.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: start=1 -> LOAD. Capture seed, taps and steps into internal registers. Later changes to the inputs do not affect the run.
- LOAD (1 cycle): load each lane state from its seed window; counter = captured steps.
  - counter 0 -> DONE.
  - otherwise -> RUN.
  - step_en is ignored in LOAD.
- RUN, when step_en=1:
  - bits_out[i] <= lane i s[0] (pre-shift value).
  - all lanes shift.
  - bit_valid pulses next cycle, coincident with the bits_out update.
  - counter decrements.
  - if counter was 1, -> DONE.
- RUN, when step_en=0: hold lane states, counter and bits_out.
- DONE (1 cycle): done=1, busy=0 -> IDLE. bits_out holds its last value until the next step or reset.
- busy: 1 exactly while FSM is in LOAD or RUN.
- abort: takes priority over step_en and start in any non-IDLE state.
  - -> IDLE next cycle; no bit_valid, no done.
  - lane states and bits_out retain their values.
- start while not in IDLE: ignored. start in the same cycle as DONE: ignored. start is accepted the following cycle in IDLE.
- Counter: counts down, no wrap. steps = 2^CNT_W-1 performs exactly that many steps.
- Lanes with taps window all zero shift in 0s; this is legal.

Optional Feature:
- Macro: LFSR_LOCKUP_DETECT_EN.
- With the macro defined:
  - In RUN on a step, a lane whose current state is all zero sets lockup[i]=1 (sticky).
  - That lane reloads its seed window instead of shifting. Its emitted bit for that step is 0.
  - lockup clears on entry to LOAD.
- Without the macro: lockup is tied to 0, and all-zero lanes shift normally (they stay zero).

Test Plan:
- W=5, NUM_LFSR=7, seed=11'b10101010101, taps=11'b11001100110, steps=3, step_en always 1:
  - busy rises the cycle after start.
  - first bit_valid gives bits_out=7'h55.
  - lane0 state after step 1 = 5'b11010; lane0 second bit = 0.
  - exactly 3 bit_valid pulses, then done pulses once and busy falls.
- steps=0 -> LOAD then DONE: done pulses 2 cycles after start, no bit_valid, busy high for 1 cycle.
- step_en pulsed every 4th cycle, steps=5 -> exactly 5 bit_valid pulses, each 1 cycle after a step_en cycle. Lane states are unchanged between ticks.
- abort asserted after 2 of 6 steps -> IDLE next cycle, busy=0, no done, bit_valid count=2. A new start then reloads the seed, and the first bits_out is again 7'h55.
- reset driven low mid-RUN (asynchronously, between clock edges) -> busy, done, bits_out, bit_valid and lockup are 0 immediately. After release, FSM is in IDLE and start is required to run.
- With LFSR_LOCKUP_DETECT_EN: seed=all zeros except lane6 window nonzero, steps=2 -> lockup=7'h3F after the first step, and lanes 0-5 emit 0. The next start clears lockup to 0.

Source files
------------

// File: rtl/lfsr_bank_ctrl.sv
// lfsr_bank_ctrl: start/busy/done sequencer for a bank of Fibonacci LFSR lanes.
// Optional LFSR_LOCKUP_DETECT_EN: flag and reseed all-zero lanes during a run.
module lfsr_bank_ctrl #(
  parameter int W        = 5,
  parameter int NUM_LFSR = 7,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    step_en,
  input  logic [CNT_W-1:0]        steps,
  input  logic [W+NUM_LFSR-2:0]   seed,
  input  logic [W+NUM_LFSR-2:0]   taps,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_LFSR-1:0]     bits_out,
  output logic                    bit_valid,
  output logic [NUM_LFSR-1:0]     lockup
);

  localparam int SW = W + NUM_LFSR - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [SW-1:0]       r_seed;
  logic [SW-1:0]       r_taps;
  logic [CNT_W-1:0]    r_steps;
  logic [CNT_W-1:0]    r_cnt;
  logic [W-1:0]        r_lane [NUM_LFSR];
  logic                r_busy;
  logic                r_done;
  logic [NUM_LFSR-1:0] r_bits;
  logic                r_valid;
  logic [NUM_LFSR-1:0] r_lockup;

  logic [W-1:0]        w_seed_win [NUM_LFSR];
  logic [W-1:0]        w_shift    [NUM_LFSR];
  logic [W-1:0]        w_next     [NUM_LFSR];
  logic [NUM_LFSR-1:0] w_bit;
  logic [NUM_LFSR-1:0] w_lock;
`ifdef LFSR_LOCKUP_DETECT_EN
  logic [NUM_LFSR-1:0] w_zero;
`endif

  // Per-lane seed window, shifted state and emitted bit for one step
  always_comb begin
    for (int i = 0; i < NUM_LFSR; i++) begin
      w_seed_win[i] = r_seed[i +: W];
      w_shift[i]    = {^(r_lane[i] & r_taps[i +: W]),
                       r_lane[i][W-1:1]};
`ifdef LFSR_LOCKUP_DETECT_EN
      w_zero[i]     = (r_lane[i] == '0);
      w_next[i]     = w_zero[i] ? w_seed_win[i] : w_shift[i];
      w_bit[i]      = w_zero[i] ? 1'b0 : r_lane[i][0];
      w_lock[i]     = w_zero[i];
`else
      w_next[i]     = w_shift[i];
      w_bit[i]      = r_lane[i][0];
      w_lock[i]     = 1'b0;
`endif
    end
  end

  // Sequencer FSM with lane datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_seed   <= '0;
      r_taps   <= '0;
      r_steps  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bits   <= '0;
      r_valid  <= 1'b0;
      r_lockup <= '0;
      for (int i = 0; i < NUM_LFSR; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_seed   <= seed;
            r_taps   <= taps;
            r_steps  <= steps;
            r_lockup <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            for (int i = 0; i < NUM_LFSR; i++) begin
              r_lane[i] <= w_seed_win[i];
            end
            r_cnt <= r_steps;
            if (r_steps == '0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (step_en) begin
            for (int i = 0; i < NUM_LFSR; i++) begin
              r_lane[i] <= w_next[i];
            end
            r_bits   <= w_bit;
            r_valid  <= 1'b1;
            r_lockup <= r_lockup | w_lock;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign bits_out  = r_bits;
  assign bit_valid = r_valid;
  assign lockup    = r_lockup;

endmodule
